// File: rtl/alarm_pkg.sv
// Shared state encoding and default sizing for the period meter.
package alarm_pkg;

   localparam int unsigned DEF_WIDTH   = 32'd32;
   localparam int unsigned DEF_TIMEOUT = 32'd100000;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input with a registered rising-edge detector.
module sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic synced_o,
   output logic rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic rise_q;
   logic level_q;

   // level_q trails the rise pulse by one cycle, so high-time counting starts the
   // cycle after the rise and a full high phase is counted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= sig_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         rise_q  <= sync2_q & ~prev_q;
         level_q <= prev_q;
      end
   end

   assign synced_o = level_q;
   assign rise_o   = rise_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous signal in system-clock cycles,
// with a stall indication when no rising edge arrives within TIMEOUT cycles.
module period_meter
   import alarm_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             valid,
   output logic             stalled
);

   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);
   localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(TIMEOUT - 32'd1);

   logic             synced_s;
   logic             rise_s;
   state_t           state_q,   state_d;
   logic [WIDTH-1:0] cnt_q,     cnt_d;
   logic [WIDTH-1:0] hi_cnt_q,  hi_cnt_d;
   logic [WIDTH-1:0] period_q,  period_d;
   logic [WIDTH-1:0] high_q,    high_d;
   logic             valid_q,   valid_d;
   logic             stalled_q, stalled_d;

   sync_edge u_sync_edge (
      .clk_i    (Clock),
      .rst_i    (Reset),
      .sig_i    (sig_in),
      .synced_o (synced_s),
      .rise_o   (rise_s)
   );

   // Next-state logic; a rise takes precedence over the timeout in the same cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_cnt_d  = hi_cnt_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      stalled_d = stalled_q;
      case (state_q)
         IDLE: begin
            cnt_d    = '0;
            hi_cnt_d = '0;
            if (rise_s) begin
               state_d   = MEASURE;
               stalled_d = 1'b0;
            end else begin
               state_d   = IDLE;
            end
         end
         MEASURE: begin
            if (rise_s) begin
               period_d  = cnt_q + ONE;
               high_d    = hi_cnt_q;
               valid_d   = 1'b1;
               cnt_d     = '0;
               hi_cnt_d  = '0;
               stalled_d = 1'b0;
            end else if (cnt_q == LAST_CNT) begin
               state_d   = IDLE;
               stalled_d = 1'b1;
               cnt_d     = '0;
               hi_cnt_d  = '0;
            end else begin
               cnt_d = cnt_q + ONE;
               if (synced_s) begin
                  hi_cnt_d = hi_cnt_q + ONE;
               end else begin
                  hi_cnt_d = hi_cnt_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_cnt_q  <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         stalled_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_cnt_q  <= hi_cnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         stalled_q <= stalled_d;
      end
   end

   assign period    = period_q;
   assign high_time = high_q;
   assign valid     = valid_q;
   assign stalled   = stalled_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: two instances (TIMEOUT 50 and 10) share one stimulus.
module tb_period_meter;

   localparam int W = 32;

   logic         Clock = 1'b0;
   logic         Reset = 1'b1;
   logic         sig_in = 1'b0;
   logic [W-1:0] period50, high50, period10, high10;
   logic         valid50, stalled50, valid10, stalled10;

   period_meter #(.WIDTH(W), .TIMEOUT(50)) dut50 (
      .Clock(Clock), .Reset(Reset), .sig_in(sig_in),
      .period(period50), .high_time(high50), .valid(valid50), .stalled(stalled50));

   period_meter #(.WIDTH(W), .TIMEOUT(10)) dut10 (
      .Clock(Clock), .Reset(Reset), .sig_in(sig_in),
      .period(period10), .high_time(high10), .valid(valid10), .stalled(stalled10));

   always #5 Clock = ~Clock;

   typedef struct {
      int div;
      int nper;
      int exp_p;
      int exp_h;
      int exp_v10;
      int exp_st10;
   } vec_t;

   vec_t vecs[5];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int nv50, nv10, last50, last10, st50, st10, chg50, chg10;
   int exp_p, exp_h, exp_sp;
   bit live50, live10;
   logic [W-1:0] pp50, ph50, pp10, ph10;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
      cyc++;
      if (valid50) begin
         nv50++;
         if (live50) begin
            check("period50", period50, exp_p);
            check("high50", high50, exp_h);
            if (last50 >= 0) check("spacing50", cyc - last50, exp_sp);
         end
         last50 = cyc;
      end
      if (valid10) begin
         nv10++;
         if (live10) begin
            check("period10", period10, exp_p);
            check("high10", high10, exp_h);
            if (last10 >= 0) check("spacing10", cyc - last10, exp_sp);
         end
         last10 = cyc;
      end
      if (!valid50 && (period50 !== pp50 || high50 !== ph50)) chg50++;
      if (!valid10 && (period10 !== pp10 || high10 !== ph10)) chg10++;
      pp50 = period50; ph50 = high50;
      pp10 = period10; ph10 = high10;
      if (stalled50) st50++;
      if (stalled10) st10++;
   endtask

   task automatic clear_stats();
      nv50 = 0; nv10 = 0; last50 = -1; last10 = -1;
      st50 = 0; st10 = 0; chg50 = 0; chg10 = 0;
      pp50 = period50; ph50 = high50; pp10 = period10; ph10 = high10;
   endtask

   task automatic apply_reset();
      live50 = 1'b0;
      live10 = 1'b0;
      sig_in = 1'b0;
      Reset  = 1'b1;
      tick();
      tick();
      check("rst_period50", period50, 0);
      check("rst_high50", high50, 0);
      check("rst_valid50", valid50, 0);
      check("rst_stalled50", stalled50, 0);
      check("rst_period10", period10, 0);
      check("rst_high10", high10, 0);
      check("rst_valid10", valid10, 0);
      check("rst_stalled10", stalled10, 0);
      Reset = 1'b0;
      clear_stats();
   endtask

   // One divider period: high for div-(div>>1) cycles, then low for div>>1 cycles.
   task automatic drive_period(input int div);
      for (int k = 0; k < div - (div >> 1); k++) begin
         sig_in = 1'b1;
         tick();
      end
      for (int k = 0; k < (div >> 1); k++) begin
         sig_in = 1'b0;
         tick();
      end
   endtask

   task automatic drive_low(input int n);
      for (int k = 0; k < n; k++) begin
         sig_in = 1'b0;
         tick();
      end
   endtask

   initial begin
      bit found;

      vecs[0] = '{div: 10, nper: 5, exp_p: 10, exp_h: 5, exp_v10: 4, exp_st10: 0};
      vecs[1] = '{div: 7,  nper: 6, exp_p: 7,  exp_h: 4, exp_v10: 5, exp_st10: 0};
      vecs[2] = '{div: 4,  nper: 6, exp_p: 4,  exp_h: 2, exp_v10: 5, exp_st10: 0};
      vecs[3] = '{div: 13, nper: 4, exp_p: 13, exp_h: 7, exp_v10: 0, exp_st10: 1};
      vecs[4] = '{div: 2,  nper: 8, exp_p: 2,  exp_h: 1, exp_v10: 7, exp_st10: 0};

      clear_stats();
      for (int v = 0; v < 5; v++) begin
         apply_reset();
         exp_p  = vecs[v].exp_p;
         exp_h  = vecs[v].exp_h;
         exp_sp = vecs[v].div;
         live50 = 1'b1;
         live10 = 1'b1;
         for (int p = 0; p < vecs[v].nper; p++) drive_period(vecs[v].div);
         drive_low(3);
         check("nvalid50", nv50, vecs[v].nper - 1);
         check("nvalid10", nv10, vecs[v].exp_v10);
         check("stall_seen50", st50 > 0, 0);
         check("stall_seen10", st10 > 0, vecs[v].exp_st10);
         check("chg_wo_valid50", chg50, 0);
         check("chg_wo_valid10", chg10, 0);
      end

      // Stop the input after three periods of 10: stall follows the last valid by 50 cycles.
      apply_reset();
      exp_p = 10; exp_h = 5; exp_sp = 10;
      live50 = 1'b1;
      for (int p = 0; p < 3; p++) drive_period(10);
      drive_low(3);
      check("stallseq_nvalid", nv50, 2);
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         sig_in = 1'b0;
         tick();
         if (stalled50) found = 1'b1;
      end
      check("stallseq_found", found, 1);
      check("stallseq_delay", cyc - last50, 50);
      check("stallseq_period_hold", period50, 10);
      check("stallseq_high_hold", high50, 5);
      nv50 = 0; last50 = -1;
      drive_period(10);
      check("rearm_nvalid", nv50, 0);
      check("rearm_stalled", stalled50, 0);
      drive_period(10);
      drive_low(3);
      check("rearm_next_nvalid", nv50, 1);
      check("rearm_next_period", period50, 10);
      check("stallseq_chg", chg50, 0);

      // Reset a few cycles into a period: partial count discarded, first rise only arms.
      apply_reset();
      live50 = 1'b1;
      for (int p = 0; p < 2; p++) drive_period(10);
      check("midrst_pre_nvalid", nv50, 1);
      for (int k = 0; k < 5; k++) begin
         sig_in = 1'b1;
         tick();
      end
      drive_low(3);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("midrst_period", period50, 0);
      check("midrst_high", high50, 0);
      check("midrst_valid", valid50, 0);
      check("midrst_stalled", stalled50, 0);
      drive_low(2);
      clear_stats();
      drive_period(10);
      check("midrst_first_rise_nvalid", nv50, 0);
      drive_period(10);
      drive_low(3);
      check("midrst_second_nvalid", nv50, 1);
      check("midrst_second_period", period50, 10);
      check("midrst_second_high", high50, 5);

      // Constant-high input: one arming edge, then stall, never a valid.
      apply_reset();
      for (int k = 0; k < 70; k++) begin
         sig_in = 1'b1;
         tick();
      end
      check("const_nvalid50", nv50, 0);
      check("const_nvalid10", nv10, 0);
      check("const_stalled50", stalled50, 1);
      check("const_stalled10", stalled10, 1);
      check("const_period50", period50, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
